// File: rtl/ula_seq_if.sv
// Handshake/bus bundle between the ALU sequencer and its decoder, operand stack and ula.
// master = environment side (decoder/stack/ula), slave = the sequencer.
interface ula_seq_if #(
    parameter int unsigned DATA_SIZE = 11,
    parameter int unsigned DEPTH_W   = 4
);
    logic                 start;
    logic [3:0]           opcode;
    logic                 busy;
    logic                 done;
    logic [1:0]           err;
    logic [DATA_SIZE-1:0] stk_rdata;
    logic [DEPTH_W-1:0]   stk_depth;
    logic                 stk_pop;
    logic                 stk_push;
    logic [DATA_SIZE-1:0] stk_wdata;
    logic [DATA_SIZE-1:0] ula_a;
    logic [DATA_SIZE-1:0] ula_b;
    logic [3:0]           ula_op;
    logic [DATA_SIZE-1:0] ula_out;

    modport master (
        output start, opcode, stk_rdata, stk_depth, ula_out,
        input  busy, done, err, stk_pop, stk_push, stk_wdata, ula_a, ula_b, ula_op
    );

    modport slave (
        input  start, opcode, stk_rdata, stk_depth, ula_out,
        output busy, done, err, stk_pop, stk_push, stk_wdata, ula_a, ula_b, ula_op
    );
endinterface

// File: rtl/ula_seq.sv
// Stack-machine ALU sequencer: pop operands, run ula, push result, one instruction per start.
// Optional macro ULA_SEQ_DIV0_TRAP_EN traps DIV with a zero top-of-stack before any pop.
module ula_seq #(
    parameter int unsigned DATA_SIZE = 11,
    parameter int unsigned DEPTH_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    ula_seq_if.slave   bus
);
    localparam int unsigned OP_W = 4;
    localparam logic [OP_W-1:0] OP_DIV  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_NOT  = OP_W'(9);
    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_UFLOW = 2'b01;
    localparam logic [1:0] ERR_OPC   = 2'b10;
    localparam logic [1:0] ERR_DIV0  = 2'b11;

    typedef enum logic [2:0] {
        IDLE, POP_B, POP_A, EXEC, PUSH, DONE, ERR
    } state_t;

    state_t               state_q;
    logic [DATA_SIZE-1:0] a_q, b_q, res_q;
    logic [OP_W-1:0]      op_q;
    logic                 busy_q, done_q, pop_q, push_q;
    logic [1:0]           err_q;

    state_t               acc_state_c;
    logic [1:0]           acc_err_c;
    logic                 is_not_c;

    // Accept-time decode of the requested opcode against stack occupancy.
    always_comb begin
        is_not_c    = (bus.opcode == OP_NOT);
        acc_state_c = is_not_c ? POP_A : POP_B;
        acc_err_c   = ERR_OK;
        if (bus.opcode > OP_NOT) begin
            acc_state_c = ERR;
            acc_err_c   = ERR_OPC;
        end else if (bus.stk_depth < (is_not_c ? DEPTH_W'(1) : DEPTH_W'(2))) begin
            acc_state_c = ERR;
            acc_err_c   = ERR_UFLOW;
        end
`ifdef ULA_SEQ_DIV0_TRAP_EN
        else if ((bus.opcode == OP_DIV) && (bus.stk_rdata == '0)) begin
            acc_state_c = ERR;
            acc_err_c   = ERR_DIV0;
        end
`else
        else if (bus.opcode == OP_DIV) begin
            acc_state_c = POP_B;
            acc_err_c   = ERR_OK;
        end
`endif
    end

    // Sequencer FSM with registered strobes and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pop_q   <= 1'b0;
            push_q  <= 1'b0;
            err_q   <= ERR_OK;
        end else begin
            pop_q  <= 1'b0;
            push_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= ERR_OK;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.opcode;
                        busy_q  <= 1'b1;
                        state_q <= acc_state_c;
                        if (acc_state_c == ERR) begin
                            done_q <= 1'b1;
                            err_q  <= acc_err_c;
                        end else begin
                            pop_q <= 1'b1;
                            if (acc_state_c == POP_A) b_q <= '0;
                        end
                    end
                end
                POP_B: begin
                    b_q     <= bus.stk_rdata;
                    pop_q   <= 1'b1;
                    state_q <= POP_A;
                end
                POP_A: begin
                    a_q     <= bus.stk_rdata;
                    state_q <= EXEC;
                end
                EXEC: begin
                    res_q   <= bus.ula_out;
                    push_q  <= 1'b1;
                    state_q <= PUSH;
                end
                PUSH: begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE, ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.stk_pop   = pop_q;
    assign bus.stk_push  = push_q;
    assign bus.stk_wdata = res_q;
    assign bus.ula_a     = a_q;
    assign bus.ula_b     = b_q;
    assign bus.ula_op    = op_q;
endmodule

// File: tb/tb_ula_seq.sv
// Directed self-checking bench for ula_seq with a behavioural stack and ula model.
module tb_ula_seq;
    localparam int unsigned DW = 11;
    localparam int unsigned DPW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ula_seq_if #(.DATA_SIZE(DW), .DEPTH_W(DPW)) bus ();
    ula_seq #(.DATA_SIZE(DW), .DEPTH_W(DPW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Stack model: rdata is the registered top, so it moves one cycle after pop/push.
    logic [DW-1:0]  mem [0:15];
    logic [DPW-1:0] sdepth = '0;
    logic           ld_en = 1'b0;
    logic [DPW-1:0] ld_depth;
    logic [DW-1:0]  ld_w0, ld_w1;
    int pop_cnt = 0, push_cnt = 0, done_cnt = 0;

    always @(posedge clk) begin
        if (ld_en) begin
            mem[0] <= ld_w0;
            mem[1] <= ld_w1;
            sdepth <= ld_depth;
        end else if (bus.stk_pop) begin
            sdepth <= sdepth - 4'd1;
        end else if (bus.stk_push) begin
            mem[sdepth] <= bus.stk_wdata;
            sdepth      <= sdepth + 4'd1;
        end
        if (bus.stk_pop)  pop_cnt  <= pop_cnt + 1;
        if (bus.stk_push) push_cnt <= push_cnt + 1;
        if (bus.done)     done_cnt <= done_cnt + 1;
    end

    assign bus.stk_depth = sdepth;
    assign bus.stk_rdata = (sdepth != 4'd0) ? mem[sdepth - 4'd1] : 11'd0;

    // Reference ula: CMP is signed, DIV by zero returns all ones.
    always_comb begin
        bus.ula_out = '0;
        case (bus.ula_op)
            4'd0: bus.ula_out = bus.ula_a + bus.ula_b;
            4'd1: bus.ula_out = bus.ula_a - bus.ula_b;
            4'd2: bus.ula_out = bus.ula_a * bus.ula_b;
            4'd3: bus.ula_out = (bus.ula_b == '0) ? '1 : bus.ula_a / bus.ula_b;
            4'd4: bus.ula_out = bus.ula_a & bus.ula_b;
            4'd5: bus.ula_out = ~(bus.ula_a & bus.ula_b);
            4'd6: bus.ula_out = bus.ula_a | bus.ula_b;
            4'd7: bus.ula_out = bus.ula_a ^ bus.ula_b;
            4'd8: bus.ula_out = ($signed(bus.ula_a) < $signed(bus.ula_b)) ? 11'h7FF :
                                (bus.ula_a == bus.ula_b) ? 11'h000 : 11'h001;
            4'd9: bus.ula_out = ~bus.ula_a;
            default: bus.ula_out = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DPW-1:0] d, input logic [DW-1:0] w0, input logic [DW-1:0] w1);
        @(negedge clk);
        ld_depth = d; ld_w0 = w0; ld_w1 = w1; ld_en = 1'b1;
        step();
        ld_en = 1'b0;
    endtask

    // Leaves the bench 1 time unit into cycle 1.
    task automatic do_start(input logic [3:0] op);
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = op;
        step();
        bus.start = 1'b0;
    endtask

    // Runs one instruction to its done pulse; optionally pokes start while busy.
    task automatic run_op(input logic [3:0] op, input bit poke,
                          output logic [DW-1:0] res, output logic [1:0] errc,
                          output int cyc, output int pops, output int pushes);
        int p0, q0;
        p0 = pop_cnt; q0 = push_cnt; res = '0; cyc = 1;
        do_start(op);
        while (!bus.done && cyc < 20) begin
            if (bus.stk_push) res = bus.stk_wdata;
            bus.start = (poke && cyc == 2);
            bus.opcode = 4'd0;
            step();
            cyc++;
        end
        bus.start = 1'b0;
        chk("done_within_bound", 32'(bus.done), 32'd1);
        errc = bus.err;
        pops = pop_cnt - p0;
        pushes = push_cnt - q0;
    endtask

    logic [DW-1:0] res;
    logic [1:0]    errc;
    int            cyc, pops, pushes, p0, q0, d0;

    initial begin
        rst_n = 1'b0; bus.start = 1'b0; bus.opcode = 4'd0;
        ld_depth = '0; ld_w0 = '0; ld_w1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_pop_push", 32'({bus.stk_pop, bus.stk_push}), 32'd0);
        chk("rst_wdata", 32'(bus.stk_wdata), 32'd0);
        chk("rst_ula", 32'({bus.ula_a, bus.ula_b, bus.ula_op}), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // SUB on [3, 5]: A=5, B=3 -> 2
        load(4'd2, 11'd5, 11'd3);
        p0 = pop_cnt; q0 = push_cnt;
        do_start(4'd1);
        chk("sub_c1_pop", 32'(bus.stk_pop), 32'd1);
        chk("sub_c1_busy", 32'(bus.busy), 32'd1);
        step();
        chk("sub_c2_pop", 32'(bus.stk_pop), 32'd1);
        step();
        chk("sub_c3_pop", 32'(bus.stk_pop), 32'd0);
        chk("sub_c3_a", 32'(bus.ula_a), 32'd5);
        chk("sub_c3_b", 32'(bus.ula_b), 32'd3);
        chk("sub_c3_op", 32'(bus.ula_op), 32'd1);
        step();
        chk("sub_c4_push", 32'(bus.stk_push), 32'd1);
        chk("sub_c4_wdata", 32'(bus.stk_wdata), 32'd2);
        step();
        chk("sub_c5_done", 32'(bus.done), 32'd1);
        chk("sub_c5_err", 32'(bus.err), 32'd0);
        chk("sub_c5_busy", 32'(bus.busy), 32'd1);
        step();
        chk("sub_c6_busy", 32'(bus.busy), 32'd0);
        chk("sub_c6_done", 32'(bus.done), 32'd0);
        chk("sub_pops", 32'(pop_cnt - p0), 32'd2);
        chk("sub_pushes", 32'(push_cnt - q0), 32'd1);
        chk("sub_depth", 32'(sdepth), 32'd1);
        chk("sub_top", 32'(bus.stk_rdata), 32'd2);

        // NOT on 10101010101 -> 01010101010, b cleared
        load(4'd1, 11'h555, 11'd0);
        do_start(4'd9);
        chk("not_c1_pop", 32'(bus.stk_pop), 32'd1);
        step();
        chk("not_c2_pop", 32'(bus.stk_pop), 32'd0);
        chk("not_c2_a", 32'(bus.ula_a), 32'h555);
        chk("not_c2_b", 32'(bus.ula_b), 32'd0);
        step();
        chk("not_c3_push", 32'(bus.stk_push), 32'd1);
        chk("not_c3_wdata", 32'(bus.stk_wdata), 32'h2AA);
        step();
        chk("not_c4_done", 32'(bus.done), 32'd1);
        chk("not_c4_err", 32'(bus.err), 32'd0);
        step();
        chk("not_depth", 32'(sdepth), 32'd1);
        chk("not_top", 32'(bus.stk_rdata), 32'h2AA);

        // Underflow: ADD with depth 1
        load(4'd1, 11'd7, 11'd0);
        p0 = pop_cnt; q0 = push_cnt;
        do_start(4'd0);
        chk("uf_c1_done", 32'(bus.done), 32'd1);
        chk("uf_c1_err", 32'(bus.err), 32'd1);
        chk("uf_c1_strobes", 32'({bus.stk_pop, bus.stk_push}), 32'd0);
        step();
        chk("uf_c2_busy", 32'(bus.busy), 32'd0);
        chk("uf_strobes", 32'((pop_cnt - p0) + (push_cnt - q0)), 32'd0);

        // Invalid opcode 12, then CMP on [7, 4]: A=4 < B=7 -> -1
        load(4'd2, 11'd4, 11'd7);
        p0 = pop_cnt;
        do_start(4'd12);
        chk("inv_c1_done", 32'(bus.done), 32'd1);
        chk("inv_c1_err", 32'(bus.err), 32'd2);
        chk("inv_c1_pop", 32'(bus.stk_pop), 32'd0);
        step();
        chk("inv_pops", 32'(pop_cnt - p0), 32'd0);
        run_op(4'd8, 1'b0, res, errc, cyc, pops, pushes);
        chk("cmp_res", 32'(res), 32'h7FF);
        chk("cmp_err", 32'(errc), 32'd0);
        chk("cmp_cycle", 32'(cyc), 32'd5);
        step();

        // DIV with zero on top: [0, 9]
        load(4'd2, 11'd9, 11'd0);
        run_op(4'd3, 1'b0, res, errc, cyc, pops, pushes);
`ifdef ULA_SEQ_DIV0_TRAP_EN
        chk("div0_err", 32'(errc), 32'd3);
        chk("div0_cycle", 32'(cyc), 32'd1);
        chk("div0_strobes", 32'(pops + pushes), 32'd0);
        step();
        chk("div0_depth", 32'(sdepth), 32'd2);
`else
        chk("div0_err", 32'(errc), 32'd0);
        chk("div0_cycle", 32'(cyc), 32'd5);
        chk("div0_pops", 32'(pops), 32'd2);
        chk("div0_pushes", 32'(pushes), 32'd1);
        chk("div0_res", 32'(res), 32'h7FF);
        step();
        chk("div0_depth", 32'(sdepth), 32'd1);
`endif

        // ADD [2, 6] with a start pulse while busy: exactly one done
        load(4'd2, 11'd6, 11'd2);
        d0 = done_cnt;
        run_op(4'd0, 1'b1, res, errc, cyc, pops, pushes);
        chk("add_res", 32'(res), 32'd8);
        chk("add_cycle", 32'(cyc), 32'd5);
        repeat (3) step();
        chk("busy_start_ignored", 32'(done_cnt - d0), 32'd1);
        chk("busy_idle", 32'(bus.busy), 32'd0);

        // Reset during POP_A of MUL on [3, 6]
        load(4'd2, 11'd6, 11'd3);
        do_start(4'd2);
        step();
        chk("mul_c2_pop", 32'(bus.stk_pop), 32'd1);
        chk("mul_c2_b", 32'(bus.ula_b), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_pop", 32'(bus.stk_pop), 32'd0);
        chk("mrst_ula", 32'({bus.ula_a, bus.ula_b, bus.ula_op}), 32'd0);
        chk("mrst_out", 32'({bus.done, bus.err, bus.stk_push, bus.stk_wdata}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        step();
        chk("mrst_idle", 32'(bus.busy), 32'd0);
        chk("mrst_depth", 32'(sdepth), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
